// File: rtl/simd_sat_au_pkg.sv
// -----------------------------------------------------------------------------
// simd_sat_au_pkg
//
// Shared definitions for the saturating add/subtract unit: operation encodings,
// the op_t enumeration and a helper that builds saturation limits for any lane
// width.
//
// Contents:
//   op_t       - 2-bit operation code (ADD, SUB, ACC_ADD, ACC_SUB)
//   op_is_sub  - true for the subtracting operations
//   op_is_acc  - true for operations that take the accumulator as operand A
//   sat_const  - largest positive / most negative two's complement value of a
//                given width (widths up to 64 bits)
// -----------------------------------------------------------------------------
package simd_sat_au_pkg;

   // Bit 0 of the code selects subtraction, bit 1 selects the accumulator as
   // operand A; the helpers below rely on that layout.
   typedef enum logic [1:0] {
      OP_ADD     = 2'b00,
      OP_SUB     = 2'b01,
      OP_ACC_ADD = 2'b10,
      OP_ACC_SUB = 2'b11
   } op_t;

   localparam int unsigned SAT_CONST_W = 64;

   function automatic logic op_is_sub(input op_t op);
      return op[0];
   endfunction

   function automatic logic op_is_acc(input op_t op);
      return op[1];
   endfunction

   // neg = 0 : 0 followed by lw-1 ones  (largest positive value)
   // neg = 1 : 1 followed by lw-1 zeros (most negative value)
   // The value is right-aligned in a 64-bit word; callers size-cast it.
   function automatic logic [SAT_CONST_W-1:0] sat_const(input int unsigned lw,
                                                        input logic neg);
      logic [SAT_CONST_W-1:0] one;
      one = {{(SAT_CONST_W-1){1'b0}}, 1'b1};
      if (neg)
         return one << (lw - 1);
      else
         return (one << (lw - 1)) - one;
   endfunction

endpackage

// File: rtl/simd_sat_au_lane.sv
// -----------------------------------------------------------------------------
// sat_lane_adder
//
// Combinational LW-bit signed add/subtract slice with carry-in. Produces the
// raw sum, the carry out of the top bit, a signed-overflow flag and the
// saturated sum for this lane on its own.
//
// Ports:
//   a        in  LW  operand A
//   b        in  LW  operand B (inverted internally when sub=1)
//   sub      in  1   subtract: use ~b as the second addend
//   cin      in  1   carry into bit 0
//   sum      out LW  unsaturated sum
//   sat_sum  out LW  sum clamped to the lane's signed range on overflow
//   ovf      out 1   signed overflow of this lane
//   cout     out 1   carry out of bit LW-1
// -----------------------------------------------------------------------------
module sat_lane_adder
   import simd_sat_au_pkg::*;
#(
   parameter int LW = 8
) (
   input  logic [LW-1:0] a,
   input  logic [LW-1:0] b,
   input  logic          sub,
   input  logic          cin,
   output logic [LW-1:0] sum,
   output logic [LW-1:0] sat_sum,
   output logic          ovf,
   output logic          cout
);

   localparam logic [LW-1:0] SAT_MAX = LW'(sat_const(LW, 1'b0));
   localparam logic [LW-1:0] SAT_MIN = LW'(sat_const(LW, 1'b1));

   logic [LW-1:0] b_eff;

   // Overflow is judged on the second addend as actually added, i.e. after the
   // inversion for subtraction. When overflow occurs both addends share a's
   // sign, so a's MSB picks which rail to clamp to.
   always_comb begin
      b_eff = sub ? ~b : b;
      {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{LW{1'b0}}, cin};
      ovf = (a[LW-1] == b_eff[LW-1]) && (sum[LW-1] != a[LW-1]);
      if (ovf)
         sat_sum = a[LW-1] ? SAT_MIN : SAT_MAX;
      else
         sat_sum = sum;
   end

endmodule

// File: rtl/simd_sat_au.sv
// -----------------------------------------------------------------------------
// simd_sat_au
//
// Two-stage pipelined saturating add/subtract unit with optional SIMD lanes,
// a saturating accumulator and a sticky overflow flag. One operation per cycle
// enters over a valid/ready handshake; its registered result appears two
// cycles after acceptance.
//
// Parameters:
//   WIDTH  datapath width (at most 64)
//   LANES  lane count in SIMD mode; WIDTH must divide evenly, lane width >= 2
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operation handshake
//   op                    ADD=00, SUB=01, ACC_ADD=10, ACC_SUB=11
//   simd                  1 = independent lanes, 0 = one full-width word
//   a, b                  signed operands (a ignored for accumulator ops)
//   acc_clr               zero the accumulator at the next edge
//   clr_sticky            clear sticky_v at the next edge
//   out_valid / out_ready result handshake
//   result                saturated result
//   lane_v                per-lane overflow (full-width mode: top bit only)
//   v, n, cout            any overflow, result sign, raw carry out of the MSB
//   sticky_v              overflow seen since the last clear
// -----------------------------------------------------------------------------
module simd_sat_au
   import simd_sat_au_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int LANES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic             simd,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             acc_clr,
   input  logic             clr_sticky,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [LANES-1:0] lane_v,
   output logic             v,
   output logic             n,
   output logic             cout,
   output logic             sticky_v
);

   localparam int LW = WIDTH / LANES;
   localparam logic [WIDTH-1:0] FULL_MAX = WIDTH'(sat_const(WIDTH, 1'b0));
   localparam logic [WIDTH-1:0] FULL_MIN = WIDTH'(sat_const(WIDTH, 1'b1));

   // Stage 1 holding registers
   logic             s1_valid;
   op_t              s1_op;
   logic             s1_simd;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;

   logic [WIDTH-1:0] acc;

   logic             s2_advance;
   logic             s2_load;
   logic             s1_sub;
   logic             s1_acc;
   logic [WIDTH-1:0] op_a;

   logic [WIDTH-1:0] raw_sum;
   logic [WIDTH-1:0] lane_sat;
   logic [LANES-1:0] lane_ovf;
   logic             top_cout;

   logic [WIDTH-1:0] comb_result;
   logic [LANES-1:0] comb_lane_v;

   // Stage 2 can take a new entry when it is empty or its result is being
   // consumed this cycle. Stage 1 frees up whenever stage 2 can take from it.
   assign s2_advance = ~out_valid | out_ready;
   assign s2_load    = s1_valid & s2_advance;
   assign in_ready   = ~s1_valid | s2_advance;

   assign s1_sub = op_is_sub(s1_op);
   assign s1_acc = op_is_acc(s1_op);

   // An accumulator op that moves to stage 2 in the same cycle as acc_clr sees
   // the cleared accumulator, so it starts a fresh sum rather than adding to
   // the stale value.
   always_comb begin
      op_a = s1_a;
      if (s1_acc)
         op_a = acc_clr ? '0 : acc;
   end

   // One adder slice per lane. In SIMD mode each slice takes the subtract bit
   // as its carry-in; in full-width mode the slices form a single ripple chain.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic          cin_l;
      logic          cout_l;
      logic          ovf_l;
      logic [LW-1:0] sum_l;
      logic [LW-1:0] sat_l;

      if (i == 0) begin : g_first
         assign cin_l = s1_sub;
      end else begin : g_chain
         assign cin_l = s1_simd ? s1_sub : g_lane[i-1].cout_l;
      end

      sat_lane_adder #(
         .LW (LW)
      ) u_lane (
         .a       (op_a[i*LW +: LW]),
         .b       (s1_b[i*LW +: LW]),
         .sub     (s1_sub),
         .cin     (cin_l),
         .sum     (sum_l),
         .sat_sum (sat_l),
         .ovf     (ovf_l),
         .cout    (cout_l)
      );

      assign raw_sum[i*LW +: LW]  = sum_l;
      assign lane_sat[i*LW +: LW] = sat_l;
      assign lane_ovf[i]          = ovf_l;
   end

   assign top_cout = g_lane[LANES-1].cout_l;

   // In full-width mode the top slice sees the true word MSBs, so its overflow
   // flag is the word overflow; the lower slices' flags are meaningless and the
   // clamp uses the full-width rails instead of the lane rails.
   always_comb begin
      comb_lane_v = '0;
      comb_result = raw_sum;
      if (s1_simd) begin
         comb_result = lane_sat;
         comb_lane_v = lane_ovf;
      end else begin
         comb_lane_v[LANES-1] = lane_ovf[LANES-1];
         if (lane_ovf[LANES-1])
            comb_result = op_a[WIDTH-1] ? FULL_MIN : FULL_MAX;
      end
   end

   // Stage 1: capture an offered operation whenever the stage is free or
   // draining into stage 2; otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_op    <= OP_ADD;
         s1_simd  <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_op   <= op_t'(op);
            s1_simd <= simd;
            s1_a    <= a;
            s1_b    <= b;
         end
      end
   end

   // Stage 2: register the result and flags as the operation arrives; drop
   // out_valid once the consumer takes a result and nothing replaces it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         lane_v    <= '0;
         v         <= 1'b0;
         n         <= 1'b0;
         cout      <= 1'b0;
      end else if (s2_load) begin
         out_valid <= 1'b1;
         result    <= comb_result;
         lane_v    <= comb_lane_v;
         v         <= |comb_lane_v;
         n         <= comb_result[WIDTH-1];
         cout      <= top_cout;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Accumulator and sticky overflow. Writes from an operation entering stage
   // 2 take priority over the clear requests, so a back-to-back accumulator op
   // sees its predecessor's result and a fresh overflow is never lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc      <= '0;
         sticky_v <= 1'b0;
      end else begin
         if (s2_load && s1_acc)
            acc <= comb_result;
         else if (acc_clr)
            acc <= '0;

         if (s2_load && (|comb_lane_v))
            sticky_v <= 1'b1;
         else if (clr_sticky)
            sticky_v <= 1'b0;
      end
   end

endmodule

// File: tb/tb_simd_sat_au.sv
// -----------------------------------------------------------------------------
// tb_simd_sat_au
//
// Directed-vector bench for simd_sat_au (WIDTH=16, LANES=2). Stimulus pushes
// the hand-computed response into a queue as each operation is accepted; an
// independent monitor pops and compares whenever the unit hands over a result.
// -----------------------------------------------------------------------------
module tb_simd_sat_au;

   localparam int WIDTH = 16;
   localparam int LANES = 2;

   typedef struct {
      logic [15:0] res;
      logic [1:0]  lv;
      logic        v;
      logic        n;
      logic        cout;
      bit          chk_sticky;
      logic        sticky;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       op;
   logic             simd;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             acc_clr;
   logic             clr_sticky;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [LANES-1:0] lane_v;
   logic             v;
   logic             n;
   logic             cout;
   logic             sticky_v;

   exp_t exp_q[$];
   int   n_compared = 0;
   int   n_failed   = 0;

   simd_sat_au #(
      .WIDTH (WIDTH),
      .LANES (LANES)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .op         (op),
      .simd       (simd),
      .a          (a),
      .b          (b),
      .acc_clr    (acc_clr),
      .clr_sticky (clr_sticky),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .lane_v     (lane_v),
      .v          (v),
      .n          (n),
      .cout       (cout),
      .sticky_v   (sticky_v)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] req);
      n_compared++;
      if (act !== req) begin
         n_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   function automatic exp_t mk(input logic [15:0] res, input logic [1:0] lv,
                               input logic vv, input logic nn, input logic cc,
                               input bit chk_s, input logic s);
      exp_t e;
      e.res = res; e.lv = lv; e.v = vv; e.n = nn; e.cout = cc;
      e.chk_sticky = chk_s; e.sticky = s;
      return e;
   endfunction

   // Called at posedge+#1; returns at posedge+#1 just after acceptance.
   task automatic applyStimulus(input logic [1:0] t_op, input logic t_simd,
                                input logic [15:0] t_a, input logic [15:0] t_b,
                                input exp_t e);
      bit accepted = 0;
      in_valid = 1'b1;
      op = t_op; simd = t_simd; a = t_a; b = t_b;
      for (int i = 0; i < 50 && !accepted; i++) begin
         @(negedge clk);
         if (in_ready) begin
            accepted = 1;
            exp_q.push_back(e);
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
      checkOutput("drain_empty", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares every handed-over result against the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_result", {16'd0, result}, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("result", {16'd0, result}, {16'd0, e.res});
            checkOutput("lane_v", {30'd0, lane_v}, {30'd0, e.lv});
            checkOutput("v", {31'd0, v}, {31'd0, e.v});
            checkOutput("n", {31'd0, n}, {31'd0, e.n});
            checkOutput("cout", {31'd0, cout}, {31'd0, e.cout});
            if (e.chk_sticky)
               checkOutput("sticky_v", {31'd0, sticky_v}, {31'd0, e.sticky});
         end
      end
   end

   // Watchdog so a wedged handshake still ends the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; op = 2'b00; simd = 1'b0;
      a = '0; b = '0; acc_clr = 1'b0; clr_sticky = 1'b0; out_ready = 1'b1;

      #1;
      checkOutput("rst_out_valid", {31'd0, out_valid}, 0);
      checkOutput("rst_result", {16'd0, result}, 0);
      checkOutput("rst_sticky", {31'd0, sticky_v}, 0);
      checkOutput("rst_lane_v", {30'd0, lane_v}, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("in_ready_after_reset", {31'd0, in_ready}, 1);

      // Full-width ADD positive overflow plus latency check
      applyStimulus(2'b00, 1'b0, 16'h7FFF, 16'h0001, mk(16'h7FFF, 2'b10, 1, 0, 0, 0, 0));
      @(negedge clk);
      checkOutput("latency_k1", {31'd0, out_valid}, 0);
      @(negedge clk);
      checkOutput("latency_k2", {31'd0, out_valid}, 1);
      @(posedge clk);
      #1;

      // Full-width SUB
      applyStimulus(2'b01, 1'b0, 16'h8000, 16'h0001, mk(16'h8000, 2'b10, 1, 1, 1, 0, 0));
      applyStimulus(2'b01, 1'b0, 16'h0005, 16'h0007, mk(16'hFFFE, 2'b00, 0, 1, 0, 0, 0));

      // SIMD ADD: both lanes saturate, then no overflow
      applyStimulus(2'b00, 1'b1, 16'h7F80, 16'h0180, mk(16'h7F80, 2'b11, 1, 0, 0, 0, 0));
      applyStimulus(2'b00, 1'b1, 16'h1020, 16'h0102, mk(16'h1122, 2'b00, 0, 0, 0, 0, 0));
      waitDrain();

      // Accumulator: clear, then three back-to-back ACC_ADDs
      acc_clr = 1'b1; clr_sticky = 1'b1;
      @(posedge clk);
      #1 acc_clr = 1'b0; clr_sticky = 1'b0;
      applyStimulus(2'b10, 1'b0, 16'hAAAA, 16'h4000, mk(16'h4000, 2'b00, 0, 0, 0, 1, 0));
      applyStimulus(2'b10, 1'b0, 16'hAAAA, 16'h4000, mk(16'h7FFF, 2'b10, 1, 0, 0, 1, 1));
      applyStimulus(2'b10, 1'b0, 16'hAAAA, 16'h4000, mk(16'h7FFF, 2'b10, 1, 0, 0, 1, 1));
      waitDrain();
      checkOutput("sticky_held", {31'd0, sticky_v}, 1);
      clr_sticky = 1'b1;
      @(posedge clk);
      #1 clr_sticky = 1'b0;
      checkOutput("sticky_cleared", {31'd0, sticky_v}, 0);

      // Back-pressure: out_ready low for four cycles while four ADDs are offered
      out_ready = 1'b0;
      fork
         begin
            applyStimulus(2'b00, 1'b0, 16'h0001, 16'h0001, mk(16'h0002, 2'b00, 0, 0, 0, 0, 0));
            applyStimulus(2'b00, 1'b0, 16'h0010, 16'h0020, mk(16'h0030, 2'b00, 0, 0, 0, 0, 0));
            applyStimulus(2'b00, 1'b0, 16'h1000, 16'h1000, mk(16'h2000, 2'b00, 0, 0, 0, 0, 0));
            applyStimulus(2'b00, 1'b0, 16'hFFFF, 16'h0001, mk(16'h0000, 2'b00, 0, 0, 1, 0, 0));
         end
         begin
            repeat (2) @(posedge clk);
            @(negedge clk);
            checkOutput("bp_out_valid", {31'd0, out_valid}, 1);
            checkOutput("bp_in_ready_low", {31'd0, in_ready}, 0);
            @(negedge clk);
            checkOutput("bp_result_stable", {16'd0, result}, 32'h0002);
            checkOutput("bp_in_ready_still_low", {31'd0, in_ready}, 0);
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      waitDrain();

      // Reset with both stages full discards everything, accumulator included
      out_ready = 1'b0;
      applyStimulus(2'b00, 1'b0, 16'h7FFF, 16'h7FFF, mk(16'h7FFF, 2'b10, 1, 0, 0, 0, 0));
      applyStimulus(2'b10, 1'b0, 16'h0000, 16'h1000, mk(16'h1000, 2'b00, 0, 0, 0, 0, 0));
      checkOutput("pre_reset_sticky", {31'd0, sticky_v}, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_reset_out_valid", {31'd0, out_valid}, 0);
      checkOutput("mid_reset_sticky", {31'd0, sticky_v}, 0);
      exp_q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1; out_ready = 1'b1;
      applyStimulus(2'b10, 1'b0, 16'h5555, 16'h0003, mk(16'h0003, 2'b00, 0, 0, 0, 1, 0));
      waitDrain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
      $finish;
   end

endmodule

// File: doc/simd_sat_au.md
# simd_sat_au

Parametrised, pipelined saturating add/subtract unit: next generation of the 16-bit add/sub/padd arithmetic unit, generalised to WIDTH bits split into LANES equal signed lanes, plus a saturating accumulate mode and sticky overflow flag. It sits in the execute stage beside the logic unit. It accepts one operation per cycle over a valid/ready handshake and returns a registered result two cycles later.

## Interface
Parameters:
- WIDTH, 16, datapath width in bits
- LANES, 2, lane count in SIMD mode; WIDTH % LANES == 0; LW = WIDTH/LANES, LW >= 2

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit accepts this cycle
- op  in  2  operation: ADD=00, SUB=01, ACC_ADD=10, ACC_SUB=11
- simd  in  1  1 = per-lane arithmetic, 0 = full-width
- a, b  in  WIDTH  signed operands; a ignored for ACC ops
- acc_clr  in  1  zero the accumulator
- clr_sticky  in  1  clear sticky_v
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  WIDTH  saturated result
- lane_v  out  LANES  per-lane overflow; full-width mode reports on bit LANES-1 only
- v  out  1  OR of lane_v
- n  out  1  MSB of result
- cout  out  1  raw carry out of bit WIDTH-1
- sticky_v  out  1  overflow seen since last clear

## Operation
- Op A is a for ADD/SUB and the accumulator for ACC ops. SUB computes A + ~b + 1.
- SIMD mode: carry chain broken at every lane boundary; each lane carry-in = sub. Full mode: one chain.
- Overflow per lane (or full word): operand signs equal (after b inversion for SUB), sum sign differs.
- Saturation: positive overflow -> 0 followed by LW-1 ones; negative overflow -> 1 followed by LW-1 zeros; otherwise the raw sum. Lanes saturate independently.
- cout is the unsaturated carry of bit WIDTH-1 (top lane in SIMD mode).
- Accumulator (WIDTH bits) loads the saturated result whenever an ACC op moves stage 1 -> stage 2; simd applies to the accumulator as to any operand.
- acc_clr zeros the accumulator at the clock edge. If an ACC op moves to stage 2 in the same cycle, it uses 0 as A and its result is written.
- sticky_v sets when a result with v=1 enters stage 2. clr_sticky clears it; a same-cycle set wins.

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, result=0, lane_v=0, v=0, n=0, cout=0, sticky_v=0, accumulator=0, both stage valids=0. in_ready=1 one cycle after release.
- Stage 1 registers op, simd, a and b on in_valid & in_ready.
- Stage 2 computes from stage 1 and the accumulator, then registers result and flags.
- Latency: accepted at edge k, so out_valid=1 after edge k+1 and visible from cycle k+2.
- Throughput: one op per cycle when out_ready=1.
- Stage 2 holds when out_valid & ~out_ready; stage 1 holds when it is full and stage 2 holds.
- in_ready = ~s1_valid | s2_advance. in_ready is combinational from out_ready; no other input-to-output path.
- Outputs stay stable while out_valid & ~out_ready.
- Back-to-back ACC ops see each other's results with no bubble.
- Reset mid-operation discards both stages and the accumulator.

## Structure
- Package simd_sat_au_pkg: op encodings, op_t typedef, and a function that builds the sat max/min constants from LW.
- Sub-module sat_lane_adder (parameter LW): a combinational lane add/sub with carry-in, overflow, carry-out and saturated sum. It is instantiated LANES times; full-width mode chains lane carries and saturates only the top-lane result across the whole word.

## Test plan
- WIDTH=16, LANES=2, ADD, simd=0, 0x7FFF + 0x0001 -> result 0x7FFF, v=1, n=0, out_valid two cycles after accept.
- SUB, simd=0, 0x8000 - 0x0001 -> 0x8000, v=1, n=1; 0x0005 - 0x0007 -> 0xFFFE, v=0, n=1, cout=0.
- ADD, simd=1, 0x7F80 + 0x0180 -> 0x7F80, lane_v=11; 0x1020 + 0x0102 -> 0x1122, lane_v=00.
- acc_clr, then ACC_ADD b=0x4000 three times back-to-back -> results 0x4000, 0x7FFF, 0x7FFF; sticky_v=1 from the second result until clr_sticky.
- Four ADDs with out_ready=0 for 4 cycles -> in_ready drops after 2 accepts; results emerge in order with none lost once out_ready=1.
- rst_n low while both stages are full -> out_valid=0 and sticky_v=0 immediately; the next ACC_ADD b=0x0003 returns 0x0003.
